// File: rtl/pc_reg_stack_if.sv
// Command/status bundle between the control unit (master) and the
// program-counter register with its return-address stack (slave).
interface pc_reg_stack_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned DW = $clog2(DEPTH + 1);

  logic             load;
  logic             clr;
  logic             inc;
  logic             call;
  logic             ret;
  logic             err_clr;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] top_out;
  logic [DW-1:0]    depth_out;
  logic             full;
  logic             empty;
  logic             wrap;
  logic             ovf_err;
  logic             unf_err;

  modport master (
    output load, clr, inc, call, ret, err_clr, data_in,
    input  data_out, top_out, depth_out, full, empty, wrap, ovf_err, unf_err
  );

  modport slave (
    input  load, clr, inc, call, ret, err_clr, data_in,
    output data_out, top_out, depth_out, full, empty, wrap, ovf_err, unf_err
  );
endinterface

// File: rtl/pc_reg_stack.sv
// Program-counter register with load/clr/inc-by-STEP and a DEPTH-entry
// return-address stack for call/ret, plus wrap pulse and sticky error flags.
module pc_reg_stack #(
  parameter int unsigned     WIDTH   = 8,
  parameter int unsigned     DEPTH   = 4,
  parameter int unsigned     STEP    = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic         clk,
  input logic         rst,
  pc_reg_stack_if.slave bus
);
  localparam int unsigned      DW      = $clog2(DEPTH + 1);
  localparam int unsigned      AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [DW-1:0]    DEPTH_W = DW'(DEPTH);
  localparam logic [DW-1:0]    ONE_D   = DW'(1);

  // Sum with carry out in the MSB; the carry drives the wrap pulse.
  function automatic logic [WIDTH:0] add_step(input logic [WIDTH-1:0] a);
    return {1'b0, a} + {1'b0, STEP_W};
  endfunction

  logic [WIDTH-1:0] data_p0;
  logic [DW-1:0]    depth_p0;
  logic             wrap_p0;
  logic             ovf_p0;
  logic             unf_p0;
  logic [WIDTH-1:0] stack_p0 [DEPTH];

  logic [WIDTH:0]   next_addr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign next_addr = add_step(data_p0);
  assign full      = (depth_p0 == DEPTH_W);
  assign empty     = (depth_p0 == '0);
  assign wr_idx    = AW'(depth_p0);
  assign top_idx   = AW'(depth_p0 - ONE_D);
  // call outranks ret, so a ret only pops when no call shares the edge
  assign push      = bus.call && !full;
  assign pop       = !bus.call && bus.ret && !empty;

  // Stage p0: register value, depth and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0  <= RST_VAL;
      depth_p0 <= '0;
      wrap_p0  <= 1'b0;
      ovf_p0   <= 1'b0;
      unf_p0   <= 1'b0;
    end else begin
      wrap_p0 <= 1'b0;
      if (bus.err_clr) begin
        ovf_p0 <= 1'b0;
        unf_p0 <= 1'b0;
      end
      if (bus.call) begin
        if (push) begin
          depth_p0 <= depth_p0 + ONE_D;
          data_p0  <= bus.data_in;
          wrap_p0  <= next_addr[WIDTH];
        end else begin
          ovf_p0 <= 1'b1;
        end
      end else if (bus.ret) begin
        if (pop) begin
          data_p0  <= stack_p0[top_idx];
          depth_p0 <= depth_p0 - ONE_D;
        end else begin
          unf_p0 <= 1'b1;
        end
      end else if (bus.load) begin
        data_p0 <= bus.data_in;
      end else if (bus.clr) begin
        data_p0 <= '0;
      end else if (bus.inc) begin
        data_p0 <= next_addr[WIDTH-1:0];
        wrap_p0 <= next_addr[WIDTH];
      end
    end
  end

  // Stack storage carries no reset; only entries below depth_p0 are visible.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      stack_p0[wr_idx] <= next_addr[WIDTH-1:0];
    end
  end

  assign bus.data_out  = data_p0;
  assign bus.top_out   = empty ? '0 : stack_p0[top_idx];
  assign bus.depth_out = depth_p0;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.wrap      = wrap_p0;
  assign bus.ovf_err   = ovf_p0;
  assign bus.unf_err   = unf_p0;
endmodule

// File: tb/tb_pc_reg_stack.sv
// Scoreboard bench for pc_reg_stack (WIDTH=8, DEPTH=4, STEP=1, RST_VAL=0).
module tb_pc_reg_stack;
  localparam logic [5:0] LD = 6'b000001;
  localparam logic [5:0] CL = 6'b000010;
  localparam logic [5:0] IN = 6'b000100;
  localparam logic [5:0] CA = 6'b001000;
  localparam logic [5:0] RT = 6'b010000;
  localparam logic [5:0] EC = 6'b100000;
  localparam logic [5:0] NO = 6'b000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passed = 0;

  pc_reg_stack_if #(.WIDTH(8), .DEPTH(4)) bus ();
  pc_reg_stack #(.WIDTH(8), .DEPTH(4), .STEP(1), .RST_VAL(8'h00)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_data = 8'h00;
  logic [7:0]  m_stack[$];
  logic        m_wrap = 1'b0;
  logic        m_ovf  = 1'b0;
  logic        m_unf  = 1'b0;
  logic [28:0] exp_q[$];
  logic [28:0] obs_q[$];

  function automatic logic [28:0] observe();
    return {bus.data_out, bus.top_out, bus.depth_out, bus.full, bus.empty,
            bus.wrap, bus.ovf_err, bus.unf_err};
  endfunction

  function automatic logic [28:0] expect_now();
    logic [7:0] top;
    top = (m_stack.size() > 0) ? m_stack[$] : 8'h00;
    return {m_data, top, 3'(m_stack.size()), m_stack.size() == 4,
            m_stack.size() == 0, m_wrap, m_ovf, m_unf};
  endfunction

  // Drive one edge worth of commands, advance the model, record both sides.
  task automatic cmd(input logic r, input logic [5:0] c, input logic [7:0] din);
    logic [8:0] sum;
    logic       nwrap;
    rst = r;
    bus.load = c[0]; bus.clr = c[1]; bus.inc = c[2];
    bus.call = c[3]; bus.ret = c[4]; bus.err_clr = c[5];
    bus.data_in = din;
    sum   = {1'b0, m_data} + 9'd1;
    nwrap = 1'b0;
    if (r) begin
      m_data = 8'h00; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (c[5]) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (c[3]) begin
        if (m_stack.size() < 4) begin
          m_stack.push_back(sum[7:0]); m_data = din; nwrap = sum[8];
        end else m_ovf = 1'b1;
      end else if (c[4]) begin
        if (m_stack.size() > 0) m_data = m_stack.pop_back();
        else m_unf = 1'b1;
      end else if (c[0]) m_data = din;
      else if (c[1]) m_data = 8'h00;
      else if (c[2]) begin m_data = sum[7:0]; nwrap = sum[8]; end
    end
    m_wrap = nwrap;
    exp_q.push_back(expect_now());
    @(posedge clk);
    #1;
    obs_q.push_back(observe());
  endtask

  task automatic test_reset();
    logic [28:0] e, o;
    cmd(1'b1, NO, 8'h00);
    cmd(1'b1, NO, 8'h00);
    cmd(1'b0, NO, 8'h00);
    checks++;
    if (bus.data_out !== 8'h00 || bus.empty !== 1'b1 || bus.full !== 1'b0)
      $display("FAIL reset_state: data=%h empty=%b full=%b, want 00/1/0",
               bus.data_out, bus.empty, bus.full);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL reset_sb: got %h want %h", o, e); else passed++;
    end
  endtask

  task automatic test_inc_wrap();
    logic [28:0] e, o;
    cmd(1'b0, LD, 8'hFE);
    checks++;
    if (bus.data_out !== 8'hFE) $display("FAIL load_fe: got %h want fe", bus.data_out); else passed++;
    cmd(1'b0, IN, 8'h00);
    checks++;
    if (bus.data_out !== 8'hFF || bus.wrap !== 1'b0)
      $display("FAIL inc_ff: data=%h wrap=%b want ff/0", bus.data_out, bus.wrap);
    else passed++;
    cmd(1'b0, IN, 8'h00);
    checks++;
    if (bus.data_out !== 8'h00 || bus.wrap !== 1'b1)
      $display("FAIL inc_wrap: data=%h wrap=%b want 00/1", bus.data_out, bus.wrap);
    else passed++;
    cmd(1'b0, NO, 8'h00);
    checks++;
    if (bus.wrap !== 1'b0) $display("FAIL wrap_pulse: got %b want 0", bus.wrap); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL inc_sb: got %h want %h", o, e); else passed++;
    end
  endtask

  task automatic test_call_ret();
    logic [28:0] e, o;
    cmd(1'b0, LD, 8'h10);
    cmd(1'b0, CA, 8'h40);
    checks++;
    if (bus.data_out !== 8'h40 || bus.top_out !== 8'h11 || bus.depth_out !== 3'd1)
      $display("FAIL call1: data=%h top=%h depth=%0d want 40/11/1", bus.data_out, bus.top_out, bus.depth_out);
    else passed++;
    cmd(1'b0, CA, 8'h80);
    checks++;
    if (bus.data_out !== 8'h80 || bus.top_out !== 8'h41 || bus.depth_out !== 3'd2)
      $display("FAIL call2: data=%h top=%h depth=%0d want 80/41/2", bus.data_out, bus.top_out, bus.depth_out);
    else passed++;
    cmd(1'b0, RT, 8'h00);
    checks++;
    if (bus.data_out !== 8'h41) $display("FAIL ret1: got %h want 41", bus.data_out); else passed++;
    cmd(1'b0, RT, 8'h00);
    checks++;
    if (bus.data_out !== 8'h11 || bus.empty !== 1'b1)
      $display("FAIL ret2: data=%h empty=%b want 11/1", bus.data_out, bus.empty);
    else passed++;
    cmd(1'b0, LD, 8'hFF);
    cmd(1'b0, CA, 8'h20);
    checks++;
    if (bus.top_out !== 8'h00 || bus.wrap !== 1'b1)
      $display("FAIL call_wrap: top=%h wrap=%b want 00/1", bus.top_out, bus.wrap);
    else passed++;
    cmd(1'b0, RT, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL callret_sb: got %h want %h", o, e); else passed++;
    end
  endtask

  task automatic test_ovf_unf();
    logic [28:0] e, o;
    cmd(1'b1, NO, 8'h00);
    for (int i = 1; i <= 4; i++) cmd(1'b0, CA, 8'(i));
    checks++;
    if (bus.full !== 1'b1) $display("FAIL fill: full=%b want 1", bus.full); else passed++;
    cmd(1'b0, CA, 8'hAA);
    checks++;
    if (bus.data_out !== 8'h04 || bus.depth_out !== 3'd4 || bus.ovf_err !== 1'b1)
      $display("FAIL ovf: data=%h depth=%0d ovf=%b want 04/4/1", bus.data_out, bus.depth_out, bus.ovf_err);
    else passed++;
    for (int i = 0; i < 4; i++) cmd(1'b0, RT, 8'h00);
    cmd(1'b0, RT, 8'h00);
    checks++;
    if (bus.data_out !== 8'h01 || bus.unf_err !== 1'b1)
      $display("FAIL unf: data=%h unf=%b want 01/1", bus.data_out, bus.unf_err);
    else passed++;
    cmd(1'b0, RT | EC, 8'h00);
    checks++;
    if (bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b1)
      $display("FAIL clr_vs_err: ovf=%b unf=%b want 0/1", bus.ovf_err, bus.unf_err);
    else passed++;
    cmd(1'b0, EC, 8'h00);
    checks++;
    if (bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0)
      $display("FAIL err_clr: ovf=%b unf=%b want 0/0", bus.ovf_err, bus.unf_err);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL ovfunf_sb: got %h want %h", o, e); else passed++;
    end
  endtask

  task automatic test_priority();
    logic [28:0] e, o;
    cmd(1'b0, LD | CL | IN, 8'h33);
    checks++;
    if (bus.data_out !== 8'h33) $display("FAIL prio_load: got %h want 33", bus.data_out); else passed++;
    cmd(1'b0, CA | RT, 8'h50);
    checks++;
    if (bus.data_out !== 8'h50 || bus.depth_out !== 3'd1 || bus.top_out !== 8'h34)
      $display("FAIL prio_call: data=%h depth=%0d top=%h want 50/1/34", bus.data_out, bus.depth_out, bus.top_out);
    else passed++;
    cmd(1'b0, CL | IN, 8'h00);
    cmd(1'b0, IN, 8'h00);
    cmd(1'b0, NO, 8'h77);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL prio_sb: got %h want %h", o, e); else passed++;
    end
  endtask

  task automatic test_reset_midseq();
    logic [28:0] e, o;
    cmd(1'b1, NO, 8'h00);
    for (int i = 0; i < 3; i++) cmd(1'b0, CA, 8'h90 + 8'(i));
    cmd(1'b1, CA, 8'hC0);
    checks++;
    if (bus.data_out !== 8'h00 || bus.depth_out !== 3'd0 || bus.top_out !== 8'h00)
      $display("FAIL rst_call: data=%h depth=%0d top=%h want 00/0/00", bus.data_out, bus.depth_out, bus.top_out);
    else passed++;
    cmd(1'b0, RT, 8'h00);
    checks++;
    if (bus.unf_err !== 1'b1) $display("FAIL rst_then_ret: unf=%b want 1", bus.unf_err); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL rstmid_sb: got %h want %h", o, e); else passed++;
    end
  endtask

  initial begin
    bus.load = 1'b0; bus.clr = 1'b0; bus.inc = 1'b0;
    bus.call = 1'b0; bus.ret = 1'b0; bus.err_clr = 1'b0;
    bus.data_in = 8'h00;
    test_reset();
    test_inc_wrap();
    test_call_ret();
    test_ovf_unf();
    test_priority();
    test_reset_midseq();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, passed=%0d of %0d", passed, checks);
    $fatal(1, "time limit");
  end
endmodule
